div_scheduler: RTL and testbench
================================

DIV_SCHEDULER -- requirements
Module: div_scheduler

Interface
REQ-001 Parameter tamanyo, default 32: operand and result width in bits.
REQ-002 Parameter N_REQ, default 4: number of requesters, at least 2.
REQ-003 Parameter TIMEOUT, default 2*tamanyo+8: maximum cycles to wait for Div_done.
REQ-004 CLK  in  1  single clock; all logic on its rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 Req_valid  in  N_REQ  per-requester request valid.
REQ-007 Req_num  in  N_REQ x tamanyo  per-requester dividend.
REQ-008 Req_den  in  N_REQ x tamanyo  per-requester divisor.
REQ-009 Req_ready  out  N_REQ  one-hot accept pulse.
REQ-010 Rsp_valid  out  1  response valid.
REQ-011 Rsp_ready  in  1  response consumed.
REQ-012 Rsp_id  out  $clog2(N_REQ)  index of the requester served.
REQ-013 Rsp_coc, Rsp_res  out  tamanyo each  quotient and remainder.
REQ-014 Rsp_divz, Rsp_err  out  1 each  divide-by-zero flag; timeout flag.
REQ-015 Div_start  out  1  level start to the shared sequential divider.
REQ-016 Div_num, Div_den  out  tamanyo each  divider operands.
REQ-017 Div_coc, Div_res  in  tamanyo each  divider results, valid only in the Div_done cycle.
REQ-018 Div_done  in  1  one-cycle divider completion pulse.

Function
REQ-019 FSM states: IDLE, ISSUE, RELEASE, RESP.
REQ-020 IDLE: with any Req_valid set, grant by round-robin starting at pointer ptr; in the same cycle pulse Req_ready[g] for 1 cycle and latch num, den and g.
REQ-021 IDLE, next state: latched den==0 -> RESP with Rsp_divz=1, Rsp_coc=all ones, Rsp_res=num; Div_start never asserted; otherwise -> ISSUE.
REQ-022 ISSUE: Div_start=1; Div_num/Div_den driven from the latches and held stable; watchdog counts up from 0.
REQ-023 ISSUE with Div_done=1: capture Div_coc/Div_res into response registers that cycle -> RELEASE.
REQ-024 ISSUE with watchdog==TIMEOUT and no Div_done: Rsp_err=1, results=0 -> RELEASE.
REQ-025 RELEASE: Div_start=0 for exactly 1 cycle -> RESP; Div_start is low for at least 1 cycle between any two operations.
REQ-026 RESP: Rsp_valid=1; Rsp_id, Rsp_coc, Rsp_res, Rsp_divz and Rsp_err stable until the Rsp_valid && Rsp_ready cycle -> IDLE, ptr=(g+1) mod N_REQ.
REQ-027 No Req_ready is issued outside IDLE; at most one operation is in flight.
REQ-028 A Div_done seen outside ISSUE is ignored.
REQ-029 Rsp_ready with Rsp_valid=0 has no effect.
REQ-030 Req_valid dropped before grant is not an error; the request is simply not served.
REQ-031 Latency for a non-zero divisor: accept-to-Rsp_valid = divider latency + 2 cycles.
REQ-032 Latency for a zero divisor: accept-to-Rsp_valid = 1 cycle.
REQ-033 The round-robin pointer wraps from N_REQ-1 to 0; a requester holding Req_valid waits at most N_REQ-1 grants.

Reset
REQ-034 RST=1 at any cycle, including mid-ISSUE: next state IDLE, ptr=0, watchdog=0.
REQ-035 Reset values of all outputs: Req_ready, Rsp_valid, Rsp_divz, Rsp_err, Div_start, Rsp_id, Rsp_coc, Rsp_res, Div_num and Div_den all 0.
REQ-036 An operation interrupted by reset produces no response; the divider recovers because Div_start=0.

Structure
REQ-037 Package div_sched_pkg holds the FSM state enum and the default values of tamanyo, N_REQ and TIMEOUT.
REQ-038 Sub-module rr_pick: combinational round-robin picker; inputs Req_valid and ptr; outputs grant index and any-valid.
REQ-039 The divider is external, connected through the Div_* ports.

Verification
REQ-040 Req_valid[0], num=100, den=7 -> Rsp_id=0, Rsp_coc=14, Rsp_res=2, divz=0, err=0.
REQ-041 After reset, all four Req_valid held with Rsp_ready=1 -> grant order 0,1,2,3,0.
REQ-042 Req_valid[2], num=55, den=0 -> Div_start stays 0; 1 cycle after accept: Rsp_divz=1, Rsp_coc=FFFFFFFF, Rsp_res=55, Rsp_id=2.
REQ-043 Rsp_ready held 0 for 10 cycles in RESP -> response fields constant, no Req_ready pulse.
REQ-044 Div_done never pulses -> TIMEOUT cycles after ISSUE entry: Rsp_err=1, Div_start low for 1 cycle, then Rsp_valid=1.
REQ-045 RST pulsed 5 cycles into ISSUE -> next cycle all outputs 0, no response; next request is served from requester 0 first.

Source files
------------

// File: rtl/div_sched_pkg.sv
// Shared definitions for the divider scheduler: FSM state encoding and
// default parameter values.
package div_sched_pkg;

  localparam int DEF_TAMANYO = 32;
  localparam int DEF_N_REQ   = 4;
  localparam int DEF_TIMEOUT = 2 * DEF_TAMANYO + 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RELEASE,
    RESP
  } state_t;

endpackage

// File: rtl/div_scheduler_rr_pick.sv
// Combinational round-robin picker: the first valid requester at or after
// ptr (wrapping) wins.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         Req_valid,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [$clog2(N_REQ)-1:0] grant,
  output logic                     any_valid
);

  localparam int IW = $clog2(N_REQ);

  int            sum;
  logic [IW-1:0] idx;

  // Scan from the farthest offset down so the closest valid index to ptr is
  // the last one written and therefore wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so
    // no path leaves it unassigned and no latch is inferred.
    grant     = '0;
    any_valid = |Req_valid;
    sum       = 0;
    idx       = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sum = int'(ptr) + i;
      if (sum >= N_REQ) sum = sum - N_REQ;
      idx = IW'(sum);
      if (Req_valid[idx]) grant = idx;
    end
  end

endmodule

// File: rtl/div_scheduler.sv
// Arbitrates N_REQ division requests onto one external sequential divider,
// with divide-by-zero shortcut, watchdog timeout and held response handshake.
module div_scheduler
  import div_sched_pkg::*;
#(
  parameter int tamanyo = DEF_TAMANYO,
  parameter int N_REQ   = DEF_N_REQ,
  parameter int TIMEOUT = 2 * tamanyo + 8
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [N_REQ-1:0]                Req_valid,
  input  logic [N_REQ-1:0][tamanyo-1:0]   Req_num,
  input  logic [N_REQ-1:0][tamanyo-1:0]   Req_den,
  output logic [N_REQ-1:0]                Req_ready,
  output logic                            Rsp_valid,
  input  logic                            Rsp_ready,
  output logic [$clog2(N_REQ)-1:0]        Rsp_id,
  output logic [tamanyo-1:0]              Rsp_coc,
  output logic [tamanyo-1:0]              Rsp_res,
  output logic                            Rsp_divz,
  output logic                            Rsp_err,
  output logic                            Div_start,
  output logic [tamanyo-1:0]              Div_num,
  output logic [tamanyo-1:0]              Div_den,
  input  logic [tamanyo-1:0]              Div_coc,
  input  logic [tamanyo-1:0]              Div_res,
  input  logic                            Div_done
);

  localparam int IW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, g_q, grant;
  logic               any_valid;
  logic [tamanyo-1:0] num_q, den_q, coc_q, res_q;
  logic               divz_q, err_q;
  logic [WW-1:0]      wd_q;
  logic               timed_out;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .Req_valid (Req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .any_valid (any_valid)
  );

  assign timed_out = (wd_q == WW'(TIMEOUT));

  always_comb begin
    state_d   = state_q;
    Req_ready = '0;
    Div_start = 1'b0;
    Rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Gated by RST so no accept pulse is shown while nothing is latched.
        if (any_valid && !RST) begin
          Req_ready[grant] = 1'b1;
          state_d = (Req_den[grant] == '0) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        Div_start = 1'b1;
        if (Div_done || timed_out) state_d = RELEASE;
      end
      RELEASE: state_d = RESP;
      RESP: begin
        Rsp_valid = 1'b1;
        if (Rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (RST) begin
      // NOTE: datapath registers are reset too because they drive outputs
      // that must read zero after reset.
      state_q <= IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      num_q   <= '0;
      den_q   <= '0;
      coc_q   <= '0;
      res_q   <= '0;
      divz_q  <= 1'b0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (any_valid) begin
            g_q    <= grant;
            num_q  <= Req_num[grant];
            den_q  <= Req_den[grant];
            err_q  <= 1'b0;
            wd_q   <= '0;
            divz_q <= (Req_den[grant] == '0);
            if (Req_den[grant] == '0) begin
              coc_q <= '1;
              res_q <= Req_num[grant];
            end
          end
        end
        ISSUE: begin
          if (Div_done) begin
            coc_q <= Div_coc;
            res_q <= Div_res;
          end else if (timed_out) begin
            err_q <= 1'b1;
            coc_q <= '0;
            res_q <= '0;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        RESP: begin
          if (Rsp_ready) ptr_q <= (g_q == IW'(N_REQ - 1)) ? '0 : g_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Rsp_id   = g_q;
  assign Rsp_coc  = coc_q;
  assign Rsp_res  = res_q;
  assign Rsp_divz = divz_q;
  assign Rsp_err  = err_q;
  assign Div_num  = num_q;
  assign Div_den  = den_q;

endmodule

// File: tb/tb_div_scheduler.sv
// Directed bench for div_scheduler with a behavioural sequential divider
// whose latency is set per scenario.
module tb_div_scheduler;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int TO = 2 * W + 8;

  logic              CLK = 1'b0;
  logic              RST;
  logic [N-1:0]      Req_valid;
  logic [N-1:0][W-1:0] Req_num, Req_den;
  logic [N-1:0]      Req_ready;
  logic              Rsp_valid, Rsp_ready;
  logic [1:0]        Rsp_id;
  logic [W-1:0]      Rsp_coc, Rsp_res;
  logic              Rsp_divz, Rsp_err;
  logic              Div_start;
  logic [W-1:0]      Div_num, Div_den;
  logic [W-1:0]      Div_coc = '0;
  logic [W-1:0]      Div_res = '0;
  logic              Div_done = 1'b0;

  int vectors = 0;
  int errors  = 0;
  int lat     = 3;
  bit dv_en   = 1'b1;
  bit stray   = 1'b0;
  int dcnt    = 0;

  div_scheduler dut (
    .CLK(CLK), .RST(RST),
    .Req_valid(Req_valid), .Req_num(Req_num), .Req_den(Req_den), .Req_ready(Req_ready),
    .Rsp_valid(Rsp_valid), .Rsp_ready(Rsp_ready), .Rsp_id(Rsp_id),
    .Rsp_coc(Rsp_coc), .Rsp_res(Rsp_res), .Rsp_divz(Rsp_divz), .Rsp_err(Rsp_err),
    .Div_start(Div_start), .Div_num(Div_num), .Div_den(Div_den),
    .Div_coc(Div_coc), .Div_res(Div_res), .Div_done(Div_done)
  );

  always #5 CLK = ~CLK;

  // Divider model: done on the lat-th cycle that Div_start is seen high.
  always @(negedge CLK) begin
    if (Div_start && dv_en) begin
      dcnt = dcnt + 1;
      if (dcnt == lat) begin
        Div_done = 1'b1;
        Div_coc  = Div_num / Div_den;
        Div_res  = Div_num % Div_den;
      end else begin
        Div_done = 1'b0;
      end
    end else begin
      dcnt     = 0;
      Div_done = stray;
      Div_coc  = 32'hDEAD_BEEF;
      Div_res  = 32'hDEAD_BEEF;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Waits for Rsp_valid; n starts at the cycles already spent since accept.
  task automatic wait_rsp(inout int n);
    while (Rsp_valid !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; Req_valid = '0; Rsp_ready = 1'b0; Req_num = '0; Req_den = '0;
    repeat (3) tick();
    vectors++;
    if ({Req_ready, Rsp_valid, Rsp_divz, Rsp_err, Div_start, Rsp_id, Rsp_coc, Rsp_res,
         Div_num, Div_den} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b valid=%b divz=%b err=%b start=%b id=%0d coc=%h res=%h num=%h den=%h required all 0",
               Req_ready, Rsp_valid, Rsp_divz, Rsp_err, Div_start, Rsp_id, Rsp_coc, Rsp_res, Div_num, Div_den);
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int n;
    lat = 3;
    Req_num[0] = 100; Req_den[0] = 7; Req_valid = 4'b0001;
    #1;
    vectors++;
    if (Req_ready !== 4'b0001) begin errors++; $display("FAIL basic_accept: got %b required 0001", Req_ready); end
    tick();
    Req_valid = '0;
    vectors++;
    if (Div_start !== 1'b1 || Div_num !== 100 || Div_den !== 7) begin
      errors++; $display("FAIL basic_issue: got start=%b num=%0d den=%0d required 1/100/7", Div_start, Div_num, Div_den);
    end
    n = 1;
    wait_rsp(n);
    vectors++;
    if (n !== lat + 2) begin errors++; $display("FAIL basic_latency: got %0d required %0d", n, lat + 2); end
    vectors++;
    if (Rsp_id !== 0 || Rsp_coc !== 14 || Rsp_res !== 2 || Rsp_divz !== 0 || Rsp_err !== 0) begin
      errors++; $display("FAIL basic_result: got id=%0d coc=%0d res=%0d divz=%b err=%b required 0/14/2/0/0",
                         Rsp_id, Rsp_coc, Rsp_res, Rsp_divz, Rsp_err);
    end
    Rsp_ready = 1'b1;
    tick();
    Rsp_ready = 1'b0;
    vectors++;
    if (Rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_handshake: got valid=%b required 0", Rsp_valid); end
  endtask

  task automatic test_divz_hold();
    int bad;
    Req_num[2] = 55; Req_den[2] = 0; Req_valid = 4'b0100;
    Req_den[0] = 3; Req_den[1] = 3; Req_den[3] = 3;
    #1;
    vectors++;
    if (Req_ready !== 4'b0100 || Div_start !== 1'b0) begin
      errors++; $display("FAIL divz_accept: got ready=%b start=%b required 0100/0", Req_ready, Div_start);
    end
    tick();
    Req_valid = 4'b1111;
    #1;
    vectors++;
    if (Rsp_valid !== 1 || Rsp_divz !== 1 || Rsp_coc !== 32'hFFFF_FFFF || Rsp_res !== 55 ||
        Rsp_id !== 2 || Rsp_err !== 0 || Div_start !== 0) begin
      errors++; $display("FAIL divz_result: got valid=%b divz=%b coc=%h res=%0d id=%0d err=%b start=%b required 1/1/ffffffff/55/2/0/0",
                         Rsp_valid, Rsp_divz, Rsp_coc, Rsp_res, Rsp_id, Rsp_err, Div_start);
    end
    bad = 0;
    repeat (10) begin
      tick();
      if (Rsp_valid !== 1 || Req_ready !== '0 || Rsp_coc !== 32'hFFFF_FFFF || Rsp_res !== 55 ||
          Rsp_id !== 2 || Rsp_divz !== 1 || Rsp_err !== 0 || Div_start !== 0) bad++;
    end
    vectors++;
    if (bad !== 0) begin errors++; $display("FAIL resp_hold: got %0d unstable cycles required 0", bad); end
    Req_valid = '0;
    Rsp_ready = 1'b1;
    tick();
    Rsp_ready = 1'b0;
    vectors++;
    if (Rsp_valid !== 1'b0) begin errors++; $display("FAIL divz_handshake: got valid=%b required 0", Rsp_valid); end
  endtask

  task automatic test_stray();
    int bad, n;
    stray = 1'b1; Rsp_ready = 1'b1;
    bad = 0;
    repeat (3) begin
      tick();
      if (Rsp_valid !== 0 || Div_start !== 0 || Req_ready !== '0) bad++;
    end
    stray = 1'b0; Rsp_ready = 1'b0;
    tick();
    vectors++;
    if (bad !== 0) begin errors++; $display("FAIL stray_done_idle: got %0d bad cycles required 0", bad); end
    lat = 1;
    Req_num[1] = 20; Req_den[1] = 6; Req_valid = 4'b0010;
    #1;
    vectors++;
    if (Req_ready !== 4'b0010) begin errors++; $display("FAIL stray_accept: got %b required 0010", Req_ready); end
    tick();
    Req_valid = '0;
    n = 1;
    wait_rsp(n);
    vectors++;
    if (n !== 3 || Rsp_id !== 1 || Rsp_coc !== 3 || Rsp_res !== 2 || Rsp_divz !== 0 || Rsp_err !== 0) begin
      errors++; $display("FAIL stray_result: got lat=%0d id=%0d coc=%0d res=%0d divz=%b err=%b required 3/1/3/2/0/0",
                         n, Rsp_id, Rsp_coc, Rsp_res, Rsp_divz, Rsp_err);
    end
    Rsp_ready = 1'b1;
    tick();
    Rsp_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    int order[5]   = '{0, 1, 2, 3, 0};
    int exp_coc[4] = '{50, 25, 17, 13};
    int exp_res[4] = '{0, 1, 1, 1};
    int ng, nrsp, gi;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int i = 0; i < N; i++) begin
      Req_num[i] = 50 + i;
      Req_den[i] = i + 1;
    end
    lat = 1; Req_valid = 4'b1111; Rsp_ready = 1'b1;
    ng = 0; nrsp = 0;
    for (int c = 0; c < 300 && nrsp < 5; c++) begin
      if (ng == 5) Req_valid = '0;
      #1;
      if (Req_ready !== '0) begin
        gi = -1;
        for (int k = 0; k < N; k++) if (Req_ready[k] === 1'b1) gi = k;
        vectors++;
        if (ng >= 5 || $countones(Req_ready) != 1 || gi != order[ng]) begin
          errors++; $display("FAIL rr_grant%0d: got ready=%b required index %0d", ng, Req_ready, (ng < 5) ? order[ng] : -1);
        end
        ng++;
      end
      if (Rsp_valid === 1'b1) begin
        vectors++;
        if (Rsp_id !== 2'(order[nrsp]) || Rsp_coc !== exp_coc[order[nrsp]] || Rsp_res !== exp_res[order[nrsp]]) begin
          errors++; $display("FAIL rr_rsp%0d: got id=%0d coc=%0d res=%0d required %0d/%0d/%0d", nrsp, Rsp_id, Rsp_coc, Rsp_res,
                             order[nrsp], exp_coc[order[nrsp]], exp_res[order[nrsp]]);
        end
        nrsp++;
      end
      tick();
    end
    Req_valid = '0; Rsp_ready = 1'b0;
    vectors++;
    if (ng !== 5 || nrsp !== 5) begin errors++; $display("FAIL rr_count: got grants=%0d rsps=%0d required 5/5", ng, nrsp); end
  endtask

  task automatic test_timeout();
    int n, bad;
    dv_en = 1'b0;
    Req_num[1] = 9; Req_den[1] = 3; Req_valid = 4'b0010;
    #1;
    vectors++;
    if (Req_ready !== 4'b0010) begin errors++; $display("FAIL to_accept: got %b required 0010", Req_ready); end
    tick();
    Req_valid = '0;
    n = 0; bad = 0;
    while (Div_start === 1'b1 && n < 500) begin
      if (Div_num !== 9 || Div_den !== 3) bad++;
      n++;
      tick();
    end
    vectors++;
    if (n !== TO + 1 || bad !== 0) begin
      errors++; $display("FAIL to_issue_len: got %0d cycles (%0d unstable) required %0d (0)", n, bad, TO + 1);
    end
    vectors++;
    if (Div_start !== 0 || Rsp_valid !== 0 || Rsp_err !== 1 || Rsp_coc !== 0 || Rsp_res !== 0) begin
      errors++; $display("FAIL to_release: got start=%b valid=%b err=%b coc=%0d res=%0d required 0/0/1/0/0",
                         Div_start, Rsp_valid, Rsp_err, Rsp_coc, Rsp_res);
    end
    tick();
    vectors++;
    if (Rsp_valid !== 1 || Rsp_err !== 1 || Rsp_divz !== 0 || Rsp_id !== 1 || Div_start !== 0) begin
      errors++; $display("FAIL to_resp: got valid=%b err=%b divz=%b id=%0d start=%b required 1/1/0/1/0",
                         Rsp_valid, Rsp_err, Rsp_divz, Rsp_id, Div_start);
    end
    Rsp_ready = 1'b1;
    tick();
    Rsp_ready = 1'b0;
    dv_en = 1'b1;
  endtask

  task automatic test_reset_mid_issue();
    int n, bad;
    dv_en = 1'b0;
    Req_num[3] = 77; Req_den[3] = 5; Req_valid = 4'b1000;
    #1;
    vectors++;
    if (Req_ready !== 4'b1000) begin errors++; $display("FAIL rst_accept: got %b required 1000", Req_ready); end
    tick();
    Req_valid = '0;
    repeat (4) tick();
    vectors++;
    if (Div_start !== 1'b1) begin errors++; $display("FAIL rst_in_issue: got start=%b required 1", Div_start); end
    RST = 1'b1;
    tick();
    vectors++;
    if ({Req_ready, Rsp_valid, Rsp_divz, Rsp_err, Div_start, Rsp_id, Rsp_coc, Rsp_res,
         Div_num, Div_den} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: got ready=%b valid=%b start=%b id=%0d num=%0d den=%0d required all 0",
                         Req_ready, Rsp_valid, Div_start, Rsp_id, Div_num, Div_den);
    end
    RST = 1'b0; dv_en = 1'b1;
    bad = 0;
    repeat (6) begin
      tick();
      if (Rsp_valid !== 0 || Div_start !== 0) bad++;
    end
    vectors++;
    if (bad !== 0) begin errors++; $display("FAIL rst_no_resp: got %0d active cycles required 0", bad); end
    for (int i = 0; i < N; i++) begin
      Req_num[i] = 50 + i;
      Req_den[i] = i + 1;
    end
    lat = 2; Req_valid = 4'b1111;
    #1;
    vectors++;
    if (Req_ready !== 4'b0001) begin errors++; $display("FAIL rst_ptr: got %b required 0001", Req_ready); end
    tick();
    Req_valid = '0;
    n = 1;
    wait_rsp(n);
    vectors++;
    if (n !== 4 || Rsp_id !== 0 || Rsp_coc !== 50 || Rsp_res !== 0 || Rsp_err !== 0) begin
      errors++; $display("FAIL rst_after: got lat=%0d id=%0d coc=%0d res=%0d err=%b required 4/0/50/0/0",
                         n, Rsp_id, Rsp_coc, Rsp_res, Rsp_err);
    end
    Rsp_ready = 1'b1;
    tick();
    Rsp_ready = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_divz_hold();
    test_stray();
    test_round_robin();
    test_timeout();
    test_reset_mid_issue();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
